// File: rtl/cache_port_arb.sv
// Two-requester arbiter sharing the cache controller's CPU-side port, with a stall watchdog.
// Build macro ARB_RR_EN: round-robin tie-break when defined; fixed priority (port 0 wins ties) otherwise.
//
// state | meaning
// IDLE  | no transaction forwarded; arbitrate any pending request
// GNT   | granted port forwarded to the cache until completion or abort
module cache_port_arb #(
  parameter int TIMEOUT = 4096,
  parameter int CW      = 13
) (
  input  logic        cpu_clk,
  input  logic        rst,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_din,
  input  logic [3:0]  p0_ctrl,
  input  logic        p0_rd,
  input  logic        p0_wr,
  output logic [31:0] p0_dout,
  output logic        p0_bsy,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_din,
  input  logic [3:0]  p1_ctrl,
  input  logic        p1_rd,
  input  logic        p1_wr,
  output logic [31:0] p1_dout,
  output logic        p1_bsy,
  output logic [31:0] m_addr,
  output logic [31:0] m_din,
  output logic [3:0]  m_ctrl,
  output logic        m_rd,
  output logic        m_wr,
  input  logic [31:0] m_dout,
  input  logic        m_bsy,
  output logic [1:0]  gnt,
  output logic        to_err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] GNT  = 1'b1;

  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] TO_PRE = CW'(TIMEOUT - 1);

  logic [0:0]    state;
  logic [1:0]    gnt_q;
  logic          last;
  logic          err_q;
  logic [CW-1:0] wd_cnt;

  logic req0, req1, in_gnt, fwd_req, done, tie_pick1, win1;

  assign req0    = p0_rd | p0_wr;
  assign req1    = p1_rd | p1_wr;
  assign in_gnt  = (state == GNT);
  assign fwd_req = in_gnt & ((gnt_q[0] & req0) | (gnt_q[1] & req1));
  assign done    = fwd_req & ~m_bsy;

`ifdef ARB_RR_EN
  assign tie_pick1 = ~last;
`else
  // last is still tracked so both builds share one register set
  assign tie_pick1 = last & 1'b0;
`endif

  assign win1 = req1 & (~req0 | tie_pick1);

  assign p0_bsy  = req0 & ~(gnt_q[0] & in_gnt & ~m_bsy);
  assign p1_bsy  = req1 & ~(gnt_q[1] & in_gnt & ~m_bsy);
  assign p0_dout = (done & gnt_q[0]) ? m_dout : 32'h0;
  assign p1_dout = (done & gnt_q[1]) ? m_dout : 32'h0;

  assign gnt    = gnt_q;
  assign to_err = err_q;

  always_comb begin
    m_addr = 32'h0;
    m_din  = 32'h0;
    m_ctrl = 4'h0;
    m_rd   = 1'b0;
    m_wr   = 1'b0;
    if (in_gnt && gnt_q[0]) begin
      m_addr = p0_addr;
      m_din  = p0_din;
      m_ctrl = p0_ctrl;
      m_rd   = p0_rd;
      m_wr   = p0_wr;
    end else if (in_gnt && gnt_q[1]) begin
      m_addr = p1_addr;
      m_din  = p1_din;
      m_ctrl = p1_ctrl;
      m_rd   = p1_rd;
      m_wr   = p1_wr;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt_q  <= 2'b00;
      last   <= 1'b1;
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state  <= GNT;
            gnt_q  <= win1 ? 2'b10 : 2'b01;
            wd_cnt <= '0;
          end
        end
        default: begin
          if (done) begin
            last  <= gnt_q[1];
            gnt_q <= 2'b00;
            state <= IDLE;
          end else if (!fwd_req) begin
            gnt_q <= 2'b00;
            state <= IDLE;
          end else begin
            // still busy: stall is flagged but the transaction keeps waiting
            if (wd_cnt != TO_MAX) wd_cnt <= wd_cnt + CW'(1);
            if (wd_cnt == TO_PRE) err_q <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_port_arb.sv
// Scoreboard bench for cache_port_arb: completions are popped from an expected queue and compared.
module tb_cache_port_arb;

  logic        cpu_clk = 1'b0;
  logic        rst;
  logic [31:0] p0_addr, p0_din, p0_dout, p1_addr, p1_din, p1_dout;
  logic [3:0]  p0_ctrl, p1_ctrl, m_ctrl;
  logic        p0_rd, p0_wr, p0_bsy, p1_rd, p1_wr, p1_bsy;
  logic [31:0] m_addr, m_din, m_dout;
  logic        m_rd, m_wr, m_bsy, to_err;
  logic [1:0]  gnt;

  cache_port_arb #(.TIMEOUT(8), .CW(4)) dut (
    .cpu_clk(cpu_clk), .rst(rst),
    .p0_addr(p0_addr), .p0_din(p0_din), .p0_ctrl(p0_ctrl), .p0_rd(p0_rd), .p0_wr(p0_wr),
    .p0_dout(p0_dout), .p0_bsy(p0_bsy),
    .p1_addr(p1_addr), .p1_din(p1_din), .p1_ctrl(p1_ctrl), .p1_rd(p1_rd), .p1_wr(p1_wr),
    .p1_dout(p1_dout), .p1_bsy(p1_bsy),
    .m_addr(m_addr), .m_din(m_din), .m_ctrl(m_ctrl), .m_rd(m_rd), .m_wr(m_wr),
    .m_dout(m_dout), .m_bsy(m_bsy), .gnt(gnt), .to_err(to_err)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    logic        port;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   done_cyc[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   comp_cnt = 0;

  // cache model: busy for wait_n cycles of each access, then returns rd_data
  logic [31:0] rd_data = 32'h0;
  logic [7:0]  wait_n = 8'd0;
  logic [7:0]  wcnt = 8'd0;
  assign m_bsy  = (m_rd | m_wr) && (wcnt < wait_n);
  assign m_dout = rd_data;

  always @(posedge cpu_clk) begin
    cyc <= cyc + 1;
    if (rst || !(m_rd | m_wr)) wcnt <= 8'd0;
    else wcnt <= wcnt + 8'd1;
  end

  logic        mon_d, mon_port;
  logic [31:0] mon_v;
  exp_t        mon_e;

  always @(negedge cpu_clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        mon_port = (i == 1);
        mon_d = mon_port ? ((p1_rd | p1_wr) && !p1_bsy) : ((p0_rd | p0_wr) && !p0_bsy);
        mon_v = mon_port ? (p1_rd ? p1_dout : m_din) : (p0_rd ? p0_dout : m_din);
        if (mon_d) begin
          comp_cnt++;
          done_cyc.push_back(cyc);
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_done port=%0d addr=%h data=%h", i, m_addr, mon_v);
          end else begin
            mon_e = exp_q.pop_front();
            if ({mon_port, m_addr, mon_v} !== {mon_e.port, mon_e.addr, mon_e.data}) begin
              bad++;
              $display("FAIL done_check got port=%0d addr=%h data=%h exp port=%0d addr=%h data=%h",
                       i, m_addr, mon_v, mon_e.port, mon_e.addr, mon_e.data);
            end
          end
        end
      end
    end
  end

  task automatic push_exp(input logic port, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    e.port = port; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    p0_addr = 0; p0_din = 0; p0_ctrl = 0; p0_rd = 0; p0_wr = 0;
    p1_addr = 0; p1_din = 0; p1_ctrl = 0; p1_rd = 0; p1_wr = 0;
    exp_q.delete();
    repeat (2) @(posedge cpu_clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_pending(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_pending got %0d outstanding exp 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge cpu_clk);
    total++;
    if ({gnt, m_rd, m_wr, to_err} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got gnt=%b rd=%b wr=%b err=%b exp 0", gnt, m_rd, m_wr, to_err);
    end
    total++;
    if ({m_addr, m_din, m_ctrl} !== 68'h0) begin
      bad++; $display("FAIL reset_bus got addr=%h din=%h ctrl=%h exp 0", m_addr, m_din, m_ctrl);
    end
    total++;
    if ({p0_bsy, p1_bsy} !== 2'b00 || (^{p0_dout, p1_dout}) === 1'bx) begin
      bad++; $display("FAIL reset_ports got bsy=%b%b dout0=%h dout1=%h", p0_bsy, p1_bsy, p0_dout, p1_dout);
    end
  endtask

  task automatic test_single_read();
    int base, done_at;
    logic p1_seen;
    do_reset();
    wait_n = 8'd3; rd_data = 32'hDEADBEEF;
    base = comp_cnt; done_at = 0; p1_seen = 1'b0;
    p0_addr = 32'h0000_1004; p0_rd = 1'b1;
    push_exp(1'b0, 32'h0000_1004, 32'hDEADBEEF);
    for (int c = 1; c <= 10; c++) begin
      @(negedge cpu_clk);
      if (p1_bsy) p1_seen = 1'b1;
      if (c == 1) begin
        total++;
        if ({gnt, p0_bsy} !== 3'b001) begin
          bad++; $display("FAIL rd_cycle1 got gnt=%b bsy=%b exp gnt=00 bsy=1", gnt, p0_bsy);
        end
      end
      if (c == 2) begin
        total++;
        if ({gnt, m_rd, m_addr} !== {2'b01, 1'b1, 32'h0000_1004}) begin
          bad++; $display("FAIL rd_cycle2 got gnt=%b m_rd=%b addr=%h exp 01 1 00001004", gnt, m_rd, m_addr);
        end
      end
      if (p0_rd && !p0_bsy) begin
        done_at = c;
        #1 p0_rd = 1'b0;
      end
    end
    total++;
    if (done_at !== 5) begin
      bad++; $display("FAIL rd_latency got cycle %0d exp 5", done_at);
    end
    total++;
    if (comp_cnt - base !== 1) begin
      bad++; $display("FAIL rd_once got %0d completions exp 1", comp_cnt - base);
    end
    total++;
    if (p1_seen !== 1'b0) begin
      bad++; $display("FAIL rd_p1_bsy got 1 exp 0");
    end
    check_pending("rd");
  endtask

  task automatic test_tie();
    int left0, left1, s;
    logic d0, d1;
    do_reset();
    wait_n = 8'd1; rd_data = 32'h1234_5678;
    s = done_cyc.size();
`ifdef ARB_RR_EN
    left0 = 2; left1 = 2;
    push_exp(1'b0, 32'h100, rd_data); push_exp(1'b1, 32'h200, rd_data);
    push_exp(1'b0, 32'h104, rd_data); push_exp(1'b1, 32'h204, rd_data);
`else
    left0 = 3; left1 = 1;
    push_exp(1'b0, 32'h100, rd_data); push_exp(1'b0, 32'h104, rd_data);
    push_exp(1'b0, 32'h108, rd_data); push_exp(1'b1, 32'h200, rd_data);
`endif
    p0_addr = 32'h100; p1_addr = 32'h200; p0_rd = 1'b1; p1_rd = 1'b1;
    for (int k = 0; k < 60 && (left0 > 0 || left1 > 0); k++) begin
      @(negedge cpu_clk);
      d0 = p0_rd && !p0_bsy;
      d1 = p1_rd && !p1_bsy;
      #1;
      if (d0) begin
        left0--;
        if (left0 == 0) p0_rd = 1'b0; else p0_addr = p0_addr + 32'h4;
      end
      if (d1) begin
        left1--;
        if (left1 == 0) p1_rd = 1'b0; else p1_addr = p1_addr + 32'h4;
      end
    end
    @(negedge cpu_clk);
    check_pending("tie");
    total++;
    if (done_cyc.size() - s !== 4) begin
      bad++; $display("FAIL tie_count got %0d exp 4", done_cyc.size() - s);
    end else begin
      for (int k = 1; k < 4; k++) begin
        total++;
        if (done_cyc[s+k] - done_cyc[s+k-1] !== 3) begin
          bad++; $display("FAIL tie_period got %0d cycles exp 3", done_cyc[s+k] - done_cyc[s+k-1]);
        end
      end
    end
  endtask

  task automatic test_byte_write();
    logic seen;
    do_reset();
    wait_n = 8'd2; seen = 1'b0;
    p1_addr = 32'h0000_2003; p1_din = 32'h0000_00A5; p1_ctrl = 4'b0001; p1_wr = 1'b1;
    push_exp(1'b1, 32'h0000_2003, 32'h0000_00A5);
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    total++;
    if ({gnt, m_wr, m_rd, m_ctrl, m_din, m_addr} !== {2'b10, 1'b1, 1'b0, 4'b0001, 32'hA5, 32'h2003}) begin
      bad++;
      $display("FAIL wr_fwd got gnt=%b wr=%b rd=%b ctrl=%b din=%h addr=%h exp 10 1 0 0001 a5 2003",
               gnt, m_wr, m_rd, m_ctrl, m_din, m_addr);
    end
    total++;
    if (p0_bsy !== 1'b0) begin
      bad++; $display("FAIL wr_p0_bsy got %b exp 0", p0_bsy);
    end
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge cpu_clk);
      if (p1_wr && !p1_bsy) seen = 1'b1;
    end
    #1 p1_wr = 1'b0;
    @(negedge cpu_clk);
    check_pending("wr");
  endtask

  task automatic test_watchdog();
    logic seen;
    do_reset();
    wait_n = 8'd10; rd_data = 32'hCAFE_0001; seen = 1'b0;
    p0_addr = 32'h300; p0_rd = 1'b1;
    push_exp(1'b0, 32'h300, 32'hCAFE_0001);
    @(negedge cpu_clk);
    for (int b = 1; b <= 9; b++) begin
      @(negedge cpu_clk);
      if (b == 8) begin
        total++;
        if (to_err !== 1'b0) begin
          bad++; $display("FAIL wd_early got %b exp 0 in busy cycle 8", to_err);
        end
      end
      if (b == 9) begin
        total++;
        if (to_err !== 1'b1) begin
          bad++; $display("FAIL wd_set got %b exp 1 after 8 busy cycles", to_err);
        end
      end
    end
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge cpu_clk);
      if (p0_rd && !p0_bsy) seen = 1'b1;
    end
    #1 p0_rd = 1'b0;
    repeat (3) @(negedge cpu_clk);
    check_pending("wd");
    total++;
    if (to_err !== 1'b1) begin
      bad++; $display("FAIL wd_sticky got %b exp 1", to_err);
    end
    do_reset();
    @(negedge cpu_clk);
    total++;
    if (to_err !== 1'b0) begin
      bad++; $display("FAIL wd_clear got %b exp 0", to_err);
    end
  endtask

  task automatic test_reset_abort();
    int base;
    do_reset();
    wait_n = 8'd20;
    p0_addr = 32'h400; p0_rd = 1'b1;
    repeat (11) @(negedge cpu_clk);
    total++;
    if ({m_rd, gnt, to_err} !== 4'b1011) begin
      bad++; $display("FAIL rst_pre got rd=%b gnt=%b err=%b exp 1 01 1", m_rd, gnt, to_err);
    end
    #1 rst = 1'b1;
    @(negedge cpu_clk);
    total++;
    if ({m_rd, gnt, to_err} !== 4'b0000) begin
      bad++; $display("FAIL rst_mid got rd=%b gnt=%b err=%b exp 0 00 0", m_rd, gnt, to_err);
    end
    p0_rd = 1'b0;
    #1 rst = 1'b0;

    do_reset();
    wait_n = 8'd5; base = comp_cnt;
    p0_addr = 32'h500; p0_rd = 1'b1;
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    #1 p0_rd = 1'b0;
    @(negedge cpu_clk);
    total++;
    if ({gnt, m_rd} !== 3'b000) begin
      bad++; $display("FAIL abort_idle got gnt=%b rd=%b exp 00 0", gnt, m_rd);
    end
    #1 begin p0_addr = 32'h600; p1_addr = 32'h700; p0_rd = 1'b1; p1_rd = 1'b1; end
    @(negedge cpu_clk);
    total++;
    if (gnt !== 2'b01) begin
      bad++; $display("FAIL abort_last got gnt=%b exp 01", gnt);
    end
    #1 begin p0_rd = 1'b0; p1_rd = 1'b0; end
    repeat (2) @(negedge cpu_clk);
    total++;
    if (comp_cnt - base !== 0) begin
      bad++; $display("FAIL abort_nodone got %0d completions exp 0", comp_cnt - base);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_byte_write();
    test_watchdog();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

endmodule
